fifo_wr_arb: RTL and testbench
==============================

Name: fifo_wr_arb

Overview:
- Round-robin arbiter that shares the single FIFO write port among NUM_REQ producers.
- Grants at most one write per cycle and drives the FIFO i_wren/i_wrdata from registers.
- Throttles on the FIFO o_full/o_alm_full flags so the FIFO never overflows.
- Optional burst hold lets a granted producer keep the port for up to MAX_BURST consecutive writes.

Parameters:
- DATA_W, 8: data width; must match the FIFO data width.
- NUM_REQ, 4: number of producers, 2..8.
- MAX_BURST, 4: maximum consecutive grants to one producer before the pointer rotates; 1 gives pure round-robin.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rstn  input  1  asynchronous active-low reset.
- req  input  NUM_REQ  per-producer write request, level.
- req_data  input  NUM_REQ*DATA_W  producer k data in bits [k*DATA_W +: DATA_W].
- gnt  output  NUM_REQ  one-hot grant pulse, registered.
- wr_en  output  1  to FIFO i_wren, registered.
- wr_data  output  DATA_W  to FIFO i_wrdata, registered.
- fifo_full  input  1  from FIFO o_full.
- fifo_alm_full  input  1  from FIFO o_alm_full; the FIFO asserts it while free entries <= K, with K >= 1.
- busy  output  1  high while in BURST state.

Behaviour:
- Reset (rstn low, asynchronous):
  - gnt=0, wr_en=0, wr_data=0, busy=0.
  - Round-robin pointer = 0, burst counter = 0, state = IDLE.
- Handshake:
  - A producer raises req[k] with req_data stable and holds both until it sees gnt[k]=1.
  - The cycle where gnt[k]=1 is the same cycle wr_en=1 with wr_data = that producer's data. The write is accepted then.
  - The producer may drop req or present new data in that same cycle.
- Latency: request sampled at edge t; gnt and wr_en asserted in cycle t..t+1; the FIFO captures the data at edge t+1.
- Issue condition at each edge, evaluated as can_wr = !fifo_full && (!fifo_alm_full || !wr_en).
  - With can_wr=0: gnt=0 and wr_en=0 next cycle; state, pointer and counter hold.
  - Net effect: back-to-back writes only while alm_full is low. When alm_full is high, one write is issued, then one idle cycle, so fifo_full is resampled after the pending write.
- State machine:
  - IDLE:
    - If can_wr and any req: grant the first requester at or after the pointer (cyclic search), load counter=1, owner=k.
    - Go to BURST if MAX_BURST>1, else stay in IDLE with pointer=k+1 mod NUM_REQ.
  - BURST:
    - If can_wr and req[owner] and counter<MAX_BURST: grant owner again, counter+1.
    - Else if req[owner] is low, or counter==MAX_BURST: pointer=owner+1 mod NUM_REQ, return to IDLE. Same edge: if can_wr and another req is present, perform the IDLE grant search from the new pointer (no bubble).
    - Else (owner still requesting, counter<MAX_BURST, can_wr=0): stall with counter held.
- Pointer and owner width: clog2(NUM_REQ); the pointer wraps NUM_REQ-1 -> 0.
- Counter width: clog2(MAX_BURST+1).
- wr_data holds its last value when wr_en=0.
- gnt is always one-hot or zero; never more than one write per cycle.
- Reset mid-burst: immediate return to reset values. A producer whose gnt was lost re-requests; data is not written.
- A req dropped without a grant is legal; no write occurs.

Test Plan:
- Single producer, req[2]=1, data 0xA5, FIFO empty -> one cycle later gnt=4'b0100, wr_en=1, wr_data=0xA5. With req held and MAX_BURST=4: four consecutive writes, then one rotation and regrant.
- All four requesting continuously, MAX_BURST=1, FIFO never almost full -> grant order 0,1,2,3,0,1..., one write every cycle, pointer wraps 3->0.
- MAX_BURST=4, req 0 and 1 held -> grants 0,0,0,0,1,1,1,1,0 with no idle cycle between owners.
- fifo_alm_full forced high, fifo_full low, req 0 held -> wr_en pattern 1,0,1,0. Then fifo_full high -> wr_en=0 permanently, busy stays 1, counter frozen.
- Depth-8 FIFO model with K=1, all four producers requesting, no reads -> exactly 8 writes accepted, no write while full; the scoreboard sees data in grant order.
- rstn pulsed low mid-burst -> gnt, wr_en and wr_data go to 0 asynchronously; after release the first grant goes to requester 0 (pointer reset).

Source files
------------

// File: rtl/fifo_wr_arb_if.sv
// Bundle of producer requests, the FIFO write port and the FIFO flags
// shared between the write arbiter and the blocks around it.
interface fifo_wr_arb_if #(
    parameter int DATA_W  = 8,
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        gnt;
    logic                      wr_en;
    logic [DATA_W-1:0]         wr_data;
    logic                      fifo_full;
    logic                      fifo_alm_full;
    logic                      busy;

    // Arbiter side: drives grants and the FIFO write port.
    modport master (
        input  req, req_data, fifo_full, fifo_alm_full,
        output gnt, wr_en, wr_data, busy
    );

    // Producer / FIFO side.
    modport slave (
        output req, req_data, fifo_full, fifo_alm_full,
        input  gnt, wr_en, wr_data, busy
    );
endinterface

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter that shares one FIFO write port among NUM_REQ
// producers. A granted producer may keep the port for up to MAX_BURST
// consecutive writes. Writes are throttled on the FIFO full and
// almost-full flags so the FIFO can never overflow.
module fifo_wr_arb #(
    parameter int DATA_W    = 8,
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rstn,
    fifo_wr_arb_if.master bus
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t             state, state_n;
    logic [PTR_W-1:0]   ptr, ptr_n;
    logic [PTR_W-1:0]   owner, owner_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [NUM_REQ-1:0] gnt_q, gnt_n;
    logic               wr_en_q, wr_en_n;
    logic [DATA_W-1:0]  wr_data_q, wr_data_n;
    logic               can_wr;
    logic               do_grant;
    logic               new_grant;
    logic [PTR_W-1:0]   sel;

    // Cyclic successor of a requester index.
    function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] i);
        if (i == PTR_W'(NUM_REQ - 1)) begin
            return '0;
        end
        return i + PTR_W'(1);
    endfunction

    // First active requester at or after start, searching cyclically.
    function automatic logic [PTR_W-1:0] pick(input logic [NUM_REQ-1:0] r,
                                              input logic [PTR_W-1:0]   start);
        logic [PTR_W-1:0] idx;
        logic [PTR_W-1:0] res;
        logic             found;
        idx   = start;
        res   = start;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && r[idx]) begin
                res   = idx;
                found = 1'b1;
            end
            idx = next_idx(idx);
        end
        return res;
    endfunction

    // With almost-full set, only issue if no write is still in flight, so
    // the full flag is always re-sampled after the previous write lands.
    assign can_wr = !bus.fifo_full && (!bus.fifo_alm_full || !wr_en_q);

    // Next-state, grant selection and write-port outputs.
    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        owner_n   = owner;
        cnt_n     = cnt;
        gnt_n     = '0;
        wr_en_n   = 1'b0;
        wr_data_n = wr_data_q;
        do_grant  = 1'b0;
        new_grant = 1'b0;
        sel       = owner;

        case (state)
            IDLE: begin
                if (can_wr && (|bus.req)) begin
                    sel       = pick(bus.req, ptr);
                    do_grant  = 1'b1;
                    new_grant = 1'b1;
                end
            end
            BURST: begin
                if (can_wr && bus.req[owner] && (cnt < CNT_W'(MAX_BURST))) begin
                    sel      = owner;
                    do_grant = 1'b1;
                    cnt_n    = cnt + CNT_W'(1);
                end else if (!bus.req[owner] || (cnt == CNT_W'(MAX_BURST))) begin
                    ptr_n   = next_idx(owner);
                    state_n = IDLE;
                    if (can_wr && (|bus.req)) begin
                        sel       = pick(bus.req, next_idx(owner));
                        do_grant  = 1'b1;
                        new_grant = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        if (new_grant) begin
            owner_n = sel;
            cnt_n   = CNT_W'(1);
            if (MAX_BURST > 1) begin
                state_n = BURST;
            end else begin
                state_n = IDLE;
                ptr_n   = next_idx(sel);
            end
        end

        if (do_grant) begin
            gnt_n     = NUM_REQ'(1) << sel;
            wr_en_n   = 1'b1;
            wr_data_n = bus.req_data[sel*DATA_W +: DATA_W];
        end
    end

    // State, arbitration bookkeeping and registered write-port outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            cnt       <= '0;
            gnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            owner     <= owner_n;
            cnt       <= cnt_n;
            gnt_q     <= gnt_n;
            wr_en_q   <= wr_en_n;
            wr_data_q <= wr_data_n;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_data = wr_data_q;
    assign bus.busy    = (state == BURST);

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb: one instance with MAX_BURST=4 and one
// with MAX_BURST=1, plus a small depth-8 FIFO occupancy model.
module tb_fifo_wr_arb;

    localparam int DW = 8;
    localparam int NR = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   total = 0;
    int   bad   = 0;

    logic full_a   = 1'b0;
    logic alm_a    = 1'b0;
    logic model_on = 1'b0;
    int   fcount   = 0;
    logic overflow = 1'b0;

    fifo_wr_arb_if #(.DATA_W(DW), .NUM_REQ(NR)) ifa ();
    fifo_wr_arb_if #(.DATA_W(DW), .NUM_REQ(NR)) ifb ();

    fifo_wr_arb #(.DATA_W(DW), .NUM_REQ(NR), .MAX_BURST(4)) dut_a (
        .clk  (clk),
        .rstn (rstn),
        .bus  (ifa.master)
    );

    fifo_wr_arb #(.DATA_W(DW), .NUM_REQ(NR), .MAX_BURST(1)) dut_b (
        .clk  (clk),
        .rstn (rstn),
        .bus  (ifb.master)
    );

    always #5 clk = ~clk;

    // Depth-8 FIFO with K=1: almost full at 7 entries, full at 8.
    assign ifa.fifo_full     = model_on ? (fcount == 8) : full_a;
    assign ifa.fifo_alm_full = model_on ? (fcount >= 7) : alm_a;

    // FIFO occupancy: a write pending on wr_en lands at this edge.
    always @(posedge clk) begin
        if (!model_on) begin
            fcount   <= 0;
            overflow <= 1'b0;
        end else if (ifa.wr_en) begin
            if (fcount == 8) overflow <= 1'b1;
            else             fcount   <= fcount + 1;
        end
    end

    task automatic do_reset();
        rstn         = 1'b0;
        ifa.req      = '0;
        ifa.req_data = '0;
        ifb.req      = '0;
        ifb.req_data = '0;
        ifb.fifo_full     = 1'b0;
        ifb.fifo_alm_full = 1'b0;
        full_a   = 1'b0;
        alm_a    = 1'b0;
        model_on = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        ifa.req = '0; ifb.req = '0;
        @(negedge clk);
        total++; if (ifa.gnt !== 4'b0000) begin bad++; $display("[TB] FAIL reset_gnt_a got=%b exp=0000", ifa.gnt); end
        total++; if (ifa.wr_en !== 1'b0) begin bad++; $display("[TB] FAIL reset_wren_a got=%b exp=0", ifa.wr_en); end
        total++; if (ifa.wr_data !== 8'h00) begin bad++; $display("[TB] FAIL reset_wrdata_a got=%h exp=00", ifa.wr_data); end
        total++; if (ifa.busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy_a got=%b exp=0", ifa.busy); end
        total++; if (ifb.gnt !== 4'b0000) begin bad++; $display("[TB] FAIL reset_gnt_b got=%b exp=0000", ifb.gnt); end
        total++; if (ifb.wr_en !== 1'b0) begin bad++; $display("[TB] FAIL reset_wren_b got=%b exp=0", ifb.wr_en); end
        do_reset();
    endtask

    task automatic test_single_burst();
        logic [7:0] exp_d;
        do_reset();
        ifa.req = 4'b0100;
        ifa.req_data[2*DW +: DW] = 8'hA5;
        // Four burst writes, rotation with regrant, one more in the new burst.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            exp_d = 8'hA5 + 8'(i);
            total++; if (ifa.gnt !== 4'b0100) begin bad++; $display("[TB] FAIL single_gnt[%0d] got=%b exp=0100", i, ifa.gnt); end
            total++; if (ifa.wr_en !== 1'b1) begin bad++; $display("[TB] FAIL single_wren[%0d] got=%b exp=1", i, ifa.wr_en); end
            total++; if (ifa.wr_data !== exp_d) begin bad++; $display("[TB] FAIL single_data[%0d] got=%h exp=%h", i, ifa.wr_data, exp_d); end
            total++; if (ifa.busy !== 1'b1) begin bad++; $display("[TB] FAIL single_busy[%0d] got=%b exp=1", i, ifa.busy); end
            ifa.req_data[2*DW +: DW] = exp_d + 8'd1;
        end
        ifa.req = '0;
        @(negedge clk);
        total++; if (ifa.gnt !== 4'b0000) begin bad++; $display("[TB] FAIL single_drop_gnt got=%b exp=0000", ifa.gnt); end
        total++; if (ifa.wr_en !== 1'b0) begin bad++; $display("[TB] FAIL single_drop_wren got=%b exp=0", ifa.wr_en); end
        total++; if (ifa.wr_data !== 8'hAA) begin bad++; $display("[TB] FAIL single_hold_data got=%h exp=aa", ifa.wr_data); end
        total++; if (ifa.busy !== 1'b0) begin bad++; $display("[TB] FAIL single_drop_busy got=%b exp=0", ifa.busy); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                  4'b0001, 4'b0010, 4'b0100, 4'b1000};
        logic [7:0] exp_d [8] = '{8'h10, 8'h11, 8'h12, 8'h13,
                                  8'h10, 8'h11, 8'h12, 8'h13};
        do_reset();
        for (int k = 0; k < NR; k++) ifb.req_data[k*DW +: DW] = 8'h10 + 8'(k);
        ifb.req = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            total++; if (ifb.gnt !== exp_g[i]) begin bad++; $display("[TB] FAIL rr_gnt[%0d] got=%b exp=%b", i, ifb.gnt, exp_g[i]); end
            total++; if (ifb.wr_en !== 1'b1) begin bad++; $display("[TB] FAIL rr_wren[%0d] got=%b exp=1", i, ifb.wr_en); end
            total++; if (ifb.wr_data !== exp_d[i]) begin bad++; $display("[TB] FAIL rr_data[%0d] got=%h exp=%h", i, ifb.wr_data, exp_d[i]); end
            total++; if (ifb.busy !== 1'b0) begin bad++; $display("[TB] FAIL rr_busy[%0d] got=%b exp=0", i, ifb.busy); end
        end
        ifb.req = '0;
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_g [9] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001,
                                  4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0001};
        logic [7:0] exp_d [9] = '{8'h20, 8'h20, 8'h20, 8'h20,
                                  8'h21, 8'h21, 8'h21, 8'h21, 8'h20};
        do_reset();
        ifa.req_data[0*DW +: DW] = 8'h20;
        ifa.req_data[1*DW +: DW] = 8'h21;
        ifa.req = 4'b0011;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            total++; if (ifa.gnt !== exp_g[i]) begin bad++; $display("[TB] FAIL b2b_gnt[%0d] got=%b exp=%b", i, ifa.gnt, exp_g[i]); end
            total++; if (ifa.wr_en !== 1'b1) begin bad++; $display("[TB] FAIL b2b_wren[%0d] got=%b exp=1", i, ifa.wr_en); end
            total++; if (ifa.wr_data !== exp_d[i]) begin bad++; $display("[TB] FAIL b2b_data[%0d] got=%h exp=%h", i, ifa.wr_data, exp_d[i]); end
        end
        ifa.req = '0;
    endtask

    task automatic test_alm_full();
        logic       exp_w [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [3:0] exp_g [3] = '{4'b0001, 4'b0001, 4'b0010};
        do_reset();
        alm_a = 1'b1;
        ifa.req_data[0*DW +: DW] = 8'h30;
        ifa.req = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++; if (ifa.wr_en !== exp_w[i]) begin bad++; $display("[TB] FAIL alm_wren[%0d] got=%b exp=%b", i, ifa.wr_en, exp_w[i]); end
            total++; if (ifa.gnt !== {3'b000, exp_w[i]}) begin bad++; $display("[TB] FAIL alm_gnt[%0d] got=%b exp=%b", i, ifa.gnt, {3'b000, exp_w[i]}); end
        end
        full_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (ifa.wr_en !== 1'b0) begin bad++; $display("[TB] FAIL full_wren[%0d] got=%b exp=0", i, ifa.wr_en); end
            total++; if (ifa.busy !== 1'b1) begin bad++; $display("[TB] FAIL full_busy[%0d] got=%b exp=1", i, ifa.busy); end
        end
        // Two burst slots remain for producer 0, then producer 1 takes over.
        full_a = 1'b0;
        alm_a  = 1'b0;
        ifa.req_data[1*DW +: DW] = 8'h31;
        ifa.req = 4'b0011;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (ifa.gnt !== exp_g[i]) begin bad++; $display("[TB] FAIL resume_gnt[%0d] got=%b exp=%b", i, ifa.gnt, exp_g[i]); end
        end
        ifa.req = '0;
    endtask

    task automatic test_fifo_model();
        logic [3:0] exp_g [8] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001,
                                  4'b0010, 4'b0010, 4'b0010, 4'b0010};
        logic [7:0] exp_d [8] = '{8'h80, 8'h81, 8'h82, 8'h83,
                                  8'h90, 8'h91, 8'h92, 8'h93};
        int seq [NR];
        int n = 0;
        do_reset();
        model_on = 1'b1;
        for (int k = 0; k < NR; k++) begin
            seq[k] = 0;
            ifa.req_data[k*DW +: DW] = 8'h80 + 8'(k*16);
        end
        ifa.req = 4'b1111;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ifa.wr_en) begin
                if (n < 8) begin
                    total++; if (ifa.gnt !== exp_g[n]) begin bad++; $display("[TB] FAIL model_gnt[%0d] got=%b exp=%b", n, ifa.gnt, exp_g[n]); end
                    total++; if (ifa.wr_data !== exp_d[n]) begin bad++; $display("[TB] FAIL model_data[%0d] got=%h exp=%h", n, ifa.wr_data, exp_d[n]); end
                end
                n++;
                for (int k = 0; k < NR; k++) begin
                    if (ifa.gnt[k]) begin
                        seq[k]++;
                        ifa.req_data[k*DW +: DW] = 8'h80 + 8'(k*16) + 8'(seq[k]);
                    end
                end
            end
        end
        total++; if (n !== 8) begin bad++; $display("[TB] FAIL model_writes got=%0d exp=8", n); end
        total++; if (fcount !== 8) begin bad++; $display("[TB] FAIL model_level got=%0d exp=8", fcount); end
        total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL model_overflow got=%b exp=0", overflow); end
        ifa.req  = '0;
        model_on = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        ifa.req_data[0*DW +: DW] = 8'h01;
        ifa.req_data[2*DW +: DW] = 8'h5A;
        ifa.req_data[3*DW +: DW] = 8'h03;
        ifa.req = 4'b0100;
        // Six grants to producer 2 leave the pointer at 3 mid-burst.
        repeat (6) @(negedge clk);
        total++; if (ifa.gnt !== 4'b0100) begin bad++; $display("[TB] FAIL mid_gnt got=%b exp=0100", ifa.gnt); end
        total++; if (ifa.busy !== 1'b1) begin bad++; $display("[TB] FAIL mid_busy got=%b exp=1", ifa.busy); end
        rstn = 1'b0;
        #1;
        total++; if (ifa.gnt !== 4'b0000) begin bad++; $display("[TB] FAIL arst_gnt got=%b exp=0000", ifa.gnt); end
        total++; if (ifa.wr_en !== 1'b0) begin bad++; $display("[TB] FAIL arst_wren got=%b exp=0", ifa.wr_en); end
        total++; if (ifa.wr_data !== 8'h00) begin bad++; $display("[TB] FAIL arst_data got=%h exp=00", ifa.wr_data); end
        total++; if (ifa.busy !== 1'b0) begin bad++; $display("[TB] FAIL arst_busy got=%b exp=0", ifa.busy); end
        @(negedge clk);
        rstn    = 1'b1;
        ifa.req = 4'b1101;
        @(negedge clk);
        total++; if (ifa.gnt !== 4'b0001) begin bad++; $display("[TB] FAIL post_rst_gnt got=%b exp=0001", ifa.gnt); end
        total++; if (ifa.wr_data !== 8'h01) begin bad++; $display("[TB] FAIL post_rst_data got=%h exp=01", ifa.wr_data); end
        ifa.req = '0;
    endtask

    // Test sequence.
    initial begin
        ifa.req = '0; ifa.req_data = '0;
        ifb.req = '0; ifb.req_data = '0;
        ifb.fifo_full = 1'b0; ifb.fifo_alm_full = 1'b0;
        test_reset();
        test_single_burst();
        test_round_robin();
        test_back_to_back();
        test_alm_full();
        test_fifo_model();
        test_reset_mid_burst();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
